// File: rtl/wb_rr_arbiter_if.sv
// rtl/wb_rr_arbiter_if.sv - Wishbone bus bundle between NM masters, the arbiter and one slave
//
// Purpose: carries every per-master and slave-side Wishbone signal of the
// round-robin arbiter so the top level only needs clock, reset and status pins.
//
// Signals (suffix _i / _o is relative to the arbiter):
//   m_cyc_i, m_stb_i, m_we_i  [NM]     per-master cycle / strobe / write enable
//   m_sel_i                   [4*NM]   byte selects, master k at [4k+3:4k]
//   m_adr_i, m_dat_i          [32*NM]  address / write data, master k at [32k+31:32k]
//   m_ack_o, m_err_o          [NM]     ack / timeout error to the granted master only
//   m_dat_o                   [32]     read data broadcast to all masters
//   s_cyc_o, s_stb_o, s_we_o           slave cycle / strobe / write enable
//   s_sel_o [4], s_adr_o [32], s_dat_o [32]  slave byte selects / address / write data
//   s_ack_i, s_dat_i [32]              slave ack / read data
//
// Modports:
//   slave  - the arbiter's view (it is the slave of the master side)
//   master - the environment's view (masters plus the user slave core)

interface wb_rr_arbiter_if #(
    parameter int NM = 2
);
    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [NM-1:0]    m_we_i;
    logic [4*NM-1:0]  m_sel_i;
    logic [32*NM-1:0] m_adr_i;
    logic [32*NM-1:0] m_dat_i;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    logic [31:0]      m_dat_o;

    logic             s_cyc_o;
    logic             s_stb_o;
    logic             s_we_o;
    logic [3:0]       s_sel_o;
    logic [31:0]      s_adr_o;
    logic [31:0]      s_dat_o;
    logic             s_ack_i;
    logic [31:0]      s_dat_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        output m_ack_o, m_err_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_dat_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
        input  m_ack_o, m_err_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
        output s_ack_i, s_dat_i
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - round-robin Wishbone classic arbiter with bus-timeout watchdog
//
// Purpose: lets NM masters share one user-area slave. A master that wins
// arbitration keeps the bus for its whole cycle (cyc high); the next grant is
// searched from the master after the last winner, so with every master
// requesting the grant order is 0,1,..,NM-1,0,... A watchdog ends a strobe
// that waits TIMEOUT cycles without an ack with a one-cycle error.
//
// Parameters:
//   NM       number of masters (2..8), master 0 wins first after reset
//   TIMEOUT  strobe cycles without ack before the error response
//   TO_W     watchdog counter width, TIMEOUT < 2**TO_W
//
// Ports:
//   wb_clk_i   in   clock
//   wb_rst_i   in   synchronous reset, active-high
//   bus        if   wb_rr_arbiter_if.slave, all master and slave Wishbone signals
//   grant_o    out  one-hot current grant, zero when idle
//   busy_o     out  high while a master owns the bus

module wb_rr_arbiter #(
    parameter int NM      = 2,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    wb_rr_arbiter_if.slave       bus,
    output logic [NM-1:0]        grant_o,
    output logic                 busy_o
);

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [NM-1:0]    grant_q, grant_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;

    logic             busy;
    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    cand;

    logic             g_cyc;
    logic             g_stb;
    logic             g_we;
    logic [3:0]       g_sel;
    logic [31:0]      g_adr;
    logic [31:0]      g_dat;

    logic             to_hit;
    logic             s_stb;
    logic             ack_any;
    logic             err_any;

    assign busy = (state_q == BUSY);

    // Round-robin search: first requester starting just after the last winner,
    // wrapping around. last_q itself is checked last, so a lone requester still wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NM; k++) begin
            cand = IW'((int'(last_q) + k) % NM);
            if (!win_found && bus.m_cyc_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Granted master's signals; everything reads as zero when nobody is granted.
    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_sel = '0;
        g_adr = '0;
        g_dat = '0;
        for (int i = 0; i < NM; i++) begin
            if (busy && (gidx_q == IW'(i))) begin
                g_cyc = bus.m_cyc_i[i];
                g_stb = bus.m_stb_i[i];
                g_we  = bus.m_we_i[i];
                g_sel = bus.m_sel_i[4*i +: 4];
                g_adr = bus.m_adr_i[32*i +: 32];
                g_dat = bus.m_dat_i[32*i +: 32];
            end
        end
    end

    // Watchdog: the counter holds the number of strobe cycles already spent
    // waiting, so it equals TIMEOUT on the (TIMEOUT+1)-th waiting cycle.
    assign to_hit = busy && (cnt_q == TO_W'(TIMEOUT));
    assign s_stb  = g_stb & ~to_hit;

    // The ack is qualified by the master's own strobe rather than s_stb so
    // that an ack landing in the watchdog cycle still completes the transfer.
    assign ack_any = busy & g_stb & bus.s_ack_i;
    assign err_any = to_hit & ~bus.s_ack_i;

    assign bus.m_ack_o = ack_any ? grant_q : '0;
    assign bus.m_err_o = err_any ? grant_q : '0;
    assign bus.m_dat_o = bus.s_dat_i;

    assign bus.s_cyc_o = g_cyc;
    assign bus.s_stb_o = s_stb;
    assign bus.s_we_o  = g_we;
    assign bus.s_sel_o = g_sel;
    assign bus.s_adr_o = g_adr;
    assign bus.s_dat_o = g_dat;

    assign grant_o = grant_q;
    assign busy_o  = busy;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (win_found) begin
                    state_d = BUSY;
                    grant_d = {{(NM-1){1'b0}}, 1'b1} << win_idx;
                    last_d  = win_idx;
                    gidx_d  = win_idx;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    // Tenure over; the next grant is decided in the IDLE cycle,
                    // which always separates two tenures.
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (bus.s_ack_i || to_hit) begin
                    cnt_d = '0;
                end else if (s_stb) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NM - 1);
            gidx_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
